accu_group_feeder: RTL and testbench

//  Transmit side of the 4-sample accumulate interface. Accepts one packed group of N samples
//  per handshake and emits them one sample per beat, LSB lane first, on a valid/ready stream

---
 rtl/accu_group_feeder.sv | 132 +++++++++++++
 tb/tb_accu_group_feeder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/accu_group_feeder.sv
// Transmit side of the accumulate interface: takes a packed group of N samples and streams
// them one lane per beat (LSB lane first), with one group active and one pending.
module accu_group_feeder #(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned N      = 4,
  localparam int unsigned SUM_W  = DATA_W + $clog2(N),
  localparam int unsigned IDX_W  = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N*DATA_W-1:0] grp_in,
  input  logic                grp_valid,
  output logic                grp_ready,
  output logic [DATA_W-1:0]   data_out,
  output logic                valid_out,
  input  logic                ready_in,
  output logic                last_out,
  output logic [IDX_W-1:0]    beat_idx,
  output logic [SUM_W-1:0]    grp_sum
);

  localparam logic [0:0]       S_IDLE = 1'b0;
  localparam logic [0:0]       S_SEND = 1'b1;
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(N - 1);

  logic [0:0]          state_q, state_d;
  logic [N*DATA_W-1:0] act_q, act_d;
  logic [SUM_W-1:0]    act_sum_q, act_sum_d;
  logic [N*DATA_W-1:0] pend_q, pend_d;
  logic [SUM_W-1:0]    pend_sum_q, pend_sum_d;
  logic                pend_full_q, pend_full_d;
  logic [IDX_W-1:0]    beat_q, beat_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic             accept;
  logic             xfer;
  logic             last_xfer;
  logic [SUM_W-1:0] in_sum;

  function automatic logic [SUM_W-1:0] lane_sum(input logic [N*DATA_W-1:0] g);
    logic [SUM_W-1:0] s;
    s = '0;
    for (int unsigned k = 0; k < N; k++) begin
      s = s + SUM_W'(g[k*DATA_W +: DATA_W]);
    end
    return s;
  endfunction

  assign grp_ready = !pend_full_q;
  assign valid_out = (state_q == S_SEND);
  assign last_out  = valid_out && (beat_q == LAST);
  assign beat_idx  = beat_q;
  assign data_out  = data_q;
  assign grp_sum   = act_sum_q;

  assign accept    = grp_valid && grp_ready;
  assign xfer      = valid_out && ready_in;
  assign last_xfer = xfer && (beat_q == LAST);
  assign in_sum    = lane_sum(grp_in);

  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    act_sum_d   = act_sum_q;
    pend_d      = pend_q;
    pend_sum_d  = pend_sum_q;
    pend_full_d = pend_full_q;
    beat_d      = beat_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          act_d     = grp_in;
          act_sum_d = in_sum;
          beat_d    = '0;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        // Last beat frees the active slot: pending wins, else a same-cycle accept lands in active.
        if (last_xfer) begin
          beat_d = '0;
          if (pend_full_q) begin
            act_d       = pend_q;
            act_sum_d   = pend_sum_q;
            pend_full_d = 1'b0;
          end else if (accept) begin
            act_d     = grp_in;
            act_sum_d = in_sum;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          if (xfer) beat_d = beat_q + 1'b1;
          if (accept) begin
            pend_d      = grp_in;
            pend_sum_d  = in_sum;
            pend_full_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    data_d = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (beat_d == IDX_W'(k)) data_d = act_d[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      act_q       <= '0;
      act_sum_q   <= '0;
      pend_q      <= '0;
      pend_sum_q  <= '0;
      pend_full_q <= 1'b0;
      beat_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      act_sum_q   <= act_sum_d;
      pend_q      <= pend_d;
      pend_sum_q  <= pend_sum_d;
      pend_full_q <= pend_full_d;
      beat_q      <= beat_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: tb/tb_accu_group_feeder.sv
// Scoreboard bench for accu_group_feeder: stimulus queues hand-computed beats, a negedge
// monitor compares every presented beat against the queue head.
module tb_accu_group_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] grp_in;
  logic        grp_valid;
  logic        grp_ready;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        ready_in;
  logic        last_out;
  logic [1:0]  beat_idx;
  logic [9:0]  grp_sum;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [1:0] i;
    logic [9:0] s;
  } beat_t;

  beat_t sb[$];
  int total = 0;
  int bad   = 0;

  accu_group_feeder #(.DATA_W(8), .N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .grp_in    (grp_in),
    .grp_valid (grp_valid),
    .grp_ready (grp_ready),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .last_out  (last_out),
    .beat_idx  (beat_idx),
    .grp_sum   (grp_sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_group(input logic [31:0] g, input logic [9:0] s);
    beat_t b;
    for (int k = 0; k < 4; k++) begin
      b.d = g[k*8 +: 8];
      b.l = (k == 3);
      b.i = 2'(k);
      b.s = s;
      sb.push_back(b);
    end
  endtask

  task automatic send_group(input logic [31:0] g, input logic [9:0] s);
    int n;
    push_group(g, s);
    grp_in    = g;
    grp_valid = 1'b1;
    n = 0;
    while (!grp_ready && n < 50) begin
      tick();
      n++;
    end
    check("accept_wait", 32'(grp_ready), 32'd1);
    tick();
    grp_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((valid_out || sb.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    check("drain_queue_empty", 32'(sb.size()), 32'd0);
    check("drain_idle", 32'(valid_out), 32'd0);
  endtask

  // Monitor: any beat on display must match the queue head; pop only on transfer.
  always @(negedge clk) begin
    if (rst_n && valid_out) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", {24'd0, data_out}, 32'hFFFF_FFFF);
      end else begin
        check("data_out", 32'(data_out), 32'(sb[0].d));
        check("last_out", 32'(last_out), 32'(sb[0].l));
        check("beat_idx", 32'(beat_idx), 32'(sb[0].i));
        check("grp_sum",  32'(grp_sum),  32'(sb[0].s));
        if (ready_in) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    grp_in    = '0;
    grp_valid = 1'b0;
    ready_in  = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_data",  32'(data_out),  32'd0);
    check("rst_last",  32'(last_out),  32'd0);
    check("rst_beat",  32'(beat_idx),  32'd0);
    check("rst_sum",   32'(grp_sum),   32'd0);
    check("rst_ready", 32'(grp_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    check("idle_no_valid", 32'(valid_out), 32'd0);

    // 1: single group
    ready_in = 1'b1;
    send_group(32'h04030201, 10'h00A);
    drain();

    // 2: back-to-back groups, no gap
    send_group(32'h04030201, 10'h00A);
    send_group(32'h08070605, 10'h01A);
    for (int k = 0; k < 7; k++) begin
      check("b2b_no_gap", 32'(valid_out), 32'd1);
      tick();
    end
    drain();

    // 3: backpressure while beat 2 is shown
    send_group(32'h04030201, 10'h00A);
    tick();
    tick();
    ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", 32'(valid_out), 32'd1);
      check("bp_data",  32'(data_out),  32'h03);
      check("bp_idx",   32'(beat_idx),  32'd2);
      tick();
    end
    ready_in = 1'b1;
    tick();
    check("bp_next_data", 32'(data_out), 32'h04);
    drain();

    // 4: pending fill with downstream stalled
    ready_in  = 1'b0;
    push_group(32'h04030201, 10'h00A);
    grp_in    = 32'h04030201;
    grp_valid = 1'b1;
    tick();
    check("pf_ready_after_first", 32'(grp_ready), 32'd1);
    push_group(32'h08070605, 10'h01A);
    grp_in = 32'h08070605;
    tick();
    check("pf_ready_full", 32'(grp_ready), 32'd0);
    grp_in = 32'h10203040;
    tick();
    check("pf_third_stalled", 32'(grp_ready), 32'd0);
    tick();
    check("pf_third_stalled2", 32'(grp_ready), 32'd0);
    push_group(32'h10203040, 10'h0A0);
    ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("pf_ready_during_drain", 32'(grp_ready), 32'd0);
    end
    tick();
    check("pf_ready_after_last", 32'(grp_ready), 32'd1);
    tick();
    grp_valid = 1'b0;
    drain();

    // 5: max values
    send_group(32'hFFFFFFFF, 10'h3FC);
    drain();

    // 6: reset mid-group
    send_group(32'h04030201, 10'h00A);
    tick();
    tick();
    rst_n = 1'b0;
    sb.delete();
    tick();
    check("mid_rst_valid", 32'(valid_out), 32'd0);
    check("mid_rst_ready", 32'(grp_ready), 32'd1);
    check("mid_rst_beat",  32'(beat_idx),  32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_valid", 32'(valid_out), 32'd0);
    check("post_rst_ready", 32'(grp_ready), 32'd1);
    send_group(32'h08070605, 10'h01A);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
